// File: rtl/mul_unit_pkg.sv
// Shared definitions for the radix-2 RV32M multiplier: mode encodings, FSM states
// and helpers that decide which operands a mode treats as signed.
package mul_unit_pkg;

  localparam int DEF_XLEN = 32;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic rs1_is_signed(input mul_mode_e mode);
    return (mode == MUL_HSS) || (mode == MUL_HSU);
  endfunction

  function automatic logic rs2_is_signed(input mul_mode_e mode);
    return (mode == MUL_HSS);
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Multi-cycle RV32M multiplier: shift-add on operand magnitudes, one product bit per
// cycle, with a two's-complement sign fix applied as the result is loaded.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_valid,
  input  logic [1:0]      mul_mode,
  input  logic [XLEN-1:0] in_A,
  input  logic [XLEN-1:0] in_B,
  output logic            mul_ready,
  output logic [XLEN-1:0] mul_out
);

  state_e              state, next_state;
  mul_mode_e           mode_in, mode_q;
  logic [CNT_W-1:0]    count;
  logic [XLEN-1:0]     mcand;
  logic [2*XLEN-1:0]   product;
  logic                neg_flag;

  logic                sign_a, sign_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       sum;
  logic [2*XLEN-1:0]   step_product, fixed_product;
  logic                start, step_en, last_step;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Abort (valid dropped mid-computation) takes priority over finishing.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (mul_valid) next_state = S_BUSY;
      S_BUSY: begin
        if (!mul_valid)                       next_state = S_IDLE;
        else if (count == CNT_W'(XLEN - 1))   next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    start     = (state == S_IDLE) && mul_valid;
    step_en   = (state == S_BUSY) && mul_valid;
    last_step = step_en && (count == CNT_W'(XLEN - 1));
  end

  always_comb begin
    mode_in = mul_mode_e'(mul_mode);
    sign_a  = rs1_is_signed(mode_in) && in_A[XLEN-1];
    sign_b  = rs2_is_signed(mode_in) && in_B[XLEN-1];
    mag_a   = sign_a ? -in_A : in_A;
    mag_b   = sign_b ? -in_B : in_B;
  end

  // The multiplier sits in the low half and is consumed LSB-first as the product shifts in.
  always_comb begin
    sum           = {1'b0, product[2*XLEN-1:XLEN]} + (product[0] ? {1'b0, mcand} : '0);
    step_product  = {sum, product[XLEN-1:1]};
    fixed_product = neg_flag ? -step_product : step_product;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_ready <= 1'b0;
      mul_out   <= '0;
      count     <= '0;
      mcand     <= '0;
      product   <= '0;
      mode_q    <= MUL_LO;
      neg_flag  <= 1'b0;
    end else begin
      mul_ready <= last_step;
      if (start) begin
        mcand    <= mag_b;
        product  <= {{XLEN{1'b0}}, mag_a};
        mode_q   <= mode_in;
        neg_flag <= sign_a ^ sign_b;
        count    <= '0;
      end else if (step_en) begin
        product <= step_product;
        count   <= count + CNT_W'(1);
        if (last_step)
          mul_out <= (mode_q == MUL_LO) ? fixed_product[XLEN-1:0]
                                        : fixed_product[2*XLEN-1:XLEN];
      end
    end
  end

endmodule
